// File: rtl/key_exp_rcon_reader_pkg.sv
// Shared definitions for the AES key-expansion sequencer: key-size codes, word
// counts, FSM states and the RotWord/xtime helpers.
package key_exp_rcon_reader_pkg;

    localparam logic [1:0] NK_SEL_128 = 2'd0;
    localparam logic [1:0] NK_SEL_192 = 2'd1;
    localparam logic [1:0] NK_SEL_256 = 2'd2;

    // Nk-1 is stored so the mod-Nk counter wraps on a plain equality compare
    localparam logic [2:0] NK_M1_128 = 3'd3;
    localparam logic [2:0] NK_M1_192 = 3'd5;
    localparam logic [2:0] NK_M1_256 = 3'd7;

    localparam logic [5:0] LAST_IDX_128 = 6'd43;
    localparam logic [5:0] LAST_IDX_192 = 6'd51;
    localparam logic [5:0] LAST_IDX_256 = 6'd59;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_REQ  = 3'd2,
        ST_CALC = 3'd3,
        ST_OUT  = 3'd4,
        ST_DONE = 3'd5
    } state_e;

    function automatic logic [2:0] nk_m1_of(input logic [1:0] nk_sel);
        case (nk_sel)
            NK_SEL_192: return NK_M1_192;
            NK_SEL_256: return NK_M1_256;
            default:    return NK_M1_128;
        endcase
    endfunction

    function automatic logic [5:0] last_idx_of(input logic [1:0] nk_sel);
        case (nk_sel)
            NK_SEL_192: return LAST_IDX_192;
            NK_SEL_256: return LAST_IDX_256;
            default:    return LAST_IDX_128;
        endcase
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/key_exp_rcon_reader_rcon_xtime.sv
// Internal Rcon generator: loads 01 on start and multiplies by x after each use.
// Only compiled into the design when RCON_XTIME_EN is defined.
`ifdef RCON_XTIME_EN
module key_exp_rcon_reader_rcon_xtime
    import key_exp_rcon_reader_pkg::*;
(
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       init_in,
    input  logic       adv_in,
    output logic [7:0] rcon_out
);

    logic [7:0] rcon_q;
    logic [7:0] rcon_d;

    always_comb begin
        rcon_d = rcon_q;
        if (init_in) begin
            rcon_d = 8'h01;
        end else if (adv_in) begin
            rcon_d = xtime(rcon_q);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rcon_q <= 8'h00;
        end else begin
            rcon_q <= rcon_d;
        end
    end

    assign rcon_out = rcon_q;

endmodule
`endif

// File: rtl/key_exp_rcon_reader.sv
// AES key-expansion sequencer streaming w[0..4*(Nr+1)-1] using external Rcon/S-box ROMs.
// Build option RCON_XTIME_EN replaces the Rcon ROM with an internal xtime register.
//
//  state | meaning
//  IDLE  | waiting for start_in
//  LOAD  | presenting the Nk raw key words
//  REQ   | ROM addresses for w[i] on the bus
//  CALC  | ROM data valid, w[i] computed and registered
//  OUT   | w[i] held valid until accepted
//  DONE  | one-cycle done pulse
module key_exp_rcon_reader
    import key_exp_rcon_reader_pkg::*;
#(
    parameter int RCON_ADDR_BITS = 6,
    parameter int MAX_NK         = 8
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      start_in,
    input  logic [1:0]                nk_sel_in,
    input  logic [255:0]              key_in,
    output logic [RCON_ADDR_BITS-1:0] rcon_addr_out,
    input  logic [7:0]                rcon_data_in,
    output logic [31:0]               sbox_addr_out,
    input  logic [31:0]               sbox_data_in,
    output logic                      wrd_valid_out,
    input  logic                      wrd_ready_in,
    output logic [31:0]               wrd_out,
    output logic [5:0]                wrd_idx_out,
    output logic                      busy_out,
    output logic                      done_out
);

    state_e                    state_q, state_d;
    logic [255:0]              key_q, key_d;
    logic [2:0]                nk_m1_q, nk_m1_d;
    logic [5:0]                last_q, last_d;
    logic [5:0]                idx_q, idx_d;
    logic [2:0]                mod_q, mod_d;
    logic [3:0]                rnd_q, rnd_d;
    logic [31:0]               window_q [MAX_NK];
    logic [31:0]               window_d [MAX_NK];
    logic [31:0]               wrd_q, wrd_d;
    logic                      valid_q, valid_d;
    logic [RCON_ADDR_BITS-1:0] rcon_addr_q, rcon_addr_d;
    logic [31:0]               sbox_addr_q, sbox_addr_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;

    logic       accept;
    logic [2:0] mod_nx;
    logic [3:0] rnd_nx;
    logic [7:0] rcon_val;
    logic [31:0] temp;
    logic [31:0] w_new;

    assign accept = (state_q == ST_LOAD || state_q == ST_OUT) && wrd_ready_in;

`ifdef RCON_XTIME_EN
    localparam bit RCON_FROM_ROM = 1'b0;
    logic rcon_unused;
    assign rcon_unused = ^rcon_data_in;

    key_exp_rcon_reader_rcon_xtime u_rcon (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .init_in  (state_q == ST_IDLE && start_in),
        .adv_in   (state_q == ST_CALC && mod_q == 3'd0),
        .rcon_out (rcon_val)
    );
`else
    localparam bit RCON_FROM_ROM = 1'b1;
    assign rcon_val = rcon_data_in;
`endif

    always_comb begin
        mod_nx = mod_q + 3'd1;
        rnd_nx = rnd_q;
        if (mod_q == nk_m1_q) begin
            mod_nx = 3'd0;
            rnd_nx = rnd_q + 4'd1;
        end
    end

    // window_q[0] is w[i-1]; window_q[Nk-1] is w[i-Nk] regardless of Nk
    always_comb begin
        temp = window_q[0];
        if (mod_q == 3'd0) begin
            temp = sbox_data_in ^ {rcon_val, 24'h0};
        end else if (nk_m1_q == NK_M1_256 && mod_q == 3'd4) begin
            temp = sbox_data_in;
        end
        w_new = window_q[nk_m1_q] ^ temp;
    end

    always_comb begin
        state_d     = state_q;
        key_d       = key_q;
        nk_m1_d     = nk_m1_q;
        last_d      = last_q;
        idx_d       = idx_q;
        mod_d       = mod_q;
        rnd_d       = rnd_q;
        window_d    = window_q;
        wrd_d       = wrd_q;
        valid_d     = valid_q;
        rcon_addr_d = rcon_addr_q;
        sbox_addr_d = sbox_addr_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        // Addresses for the next word are issued on the accept that moves into REQ
        if (accept) begin
            window_d[0] = wrd_q;
            for (int k = 1; k < MAX_NK; k++) begin
                window_d[k] = window_q[k-1];
            end
            idx_d       = idx_q + 6'd1;
            mod_d       = mod_nx;
            rnd_d       = rnd_nx;
            sbox_addr_d = (mod_nx == 3'd0) ? rot_word(wrd_q) : wrd_q;
            if (RCON_FROM_ROM) begin
                rcon_addr_d = RCON_ADDR_BITS'(rnd_nx);
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (start_in) begin
                    state_d = ST_LOAD;
                    key_d   = {key_in[223:0], 32'h0};
                    nk_m1_d = nk_m1_of(nk_sel_in);
                    last_d  = last_idx_of(nk_sel_in);
                    idx_d   = 6'd0;
                    mod_d   = 3'd0;
                    rnd_d   = 4'd0;
                    wrd_d   = key_in[255:224];
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    key_d = {key_q[223:0], 32'h0};
                    if (mod_q == nk_m1_q) begin
                        state_d = ST_REQ;
                        valid_d = 1'b0;
                    end else begin
                        wrd_d = key_q[255:224];
                    end
                end
            end
            ST_REQ: begin
                state_d = ST_CALC;
            end
            ST_CALC: begin
                wrd_d   = w_new;
                valid_d = 1'b1;
                state_d = ST_OUT;
            end
            ST_OUT: begin
                if (accept) begin
                    valid_d = 1'b0;
                    if (idx_q == last_q) begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= ST_IDLE;
            key_q       <= '0;
            nk_m1_q     <= '0;
            last_q      <= '0;
            idx_q       <= '0;
            mod_q       <= '0;
            rnd_q       <= '0;
            window_q    <= '{default: '0};
            wrd_q       <= '0;
            valid_q     <= 1'b0;
            rcon_addr_q <= '0;
            sbox_addr_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            nk_m1_q     <= nk_m1_d;
            last_q      <= last_d;
            idx_q       <= idx_d;
            mod_q       <= mod_d;
            rnd_q       <= rnd_d;
            window_q    <= window_d;
            wrd_q       <= wrd_d;
            valid_q     <= valid_d;
            rcon_addr_q <= rcon_addr_d;
            sbox_addr_q <= sbox_addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign rcon_addr_out = rcon_addr_q;
    assign sbox_addr_out = sbox_addr_q;
    assign wrd_valid_out = valid_q;
    assign wrd_out       = wrd_q;
    assign wrd_idx_out   = idx_q;
    assign busy_out      = busy_q;
    assign done_out      = done_q;

endmodule

// File: tb/tb_key_exp_rcon_reader.sv
// Bench for key_exp_rcon_reader: ROM models, a plain FIPS-197 key-expansion reference
// and randomized backpressure/keys; build with or without RCON_XTIME_EN.
module tb_key_exp_rcon_reader;

    logic         clk_in = 1'b0;
    logic         rst_in;
    logic         start_in;
    logic [1:0]   nk_sel_in;
    logic [255:0] key_in;
    logic [5:0]   rcon_addr_out;
    logic [7:0]   rcon_data_in;
    logic [31:0]  sbox_addr_out;
    logic [31:0]  sbox_data_in;
    logic         wrd_valid_out;
    logic         wrd_ready_in;
    logic [31:0]  wrd_out;
    logic [5:0]   wrd_idx_out;
    logic         busy_out;
    logic         done_out;

    key_exp_rcon_reader dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .start_in      (start_in),
        .nk_sel_in     (nk_sel_in),
        .key_in        (key_in),
        .rcon_addr_out (rcon_addr_out),
        .rcon_data_in  (rcon_data_in),
        .sbox_addr_out (sbox_addr_out),
        .sbox_data_in  (sbox_data_in),
        .wrd_valid_out (wrd_valid_out),
        .wrd_ready_in  (wrd_ready_in),
        .wrd_out       (wrd_out),
        .wrd_idx_out   (wrd_idx_out),
        .busy_out      (busy_out),
        .done_out      (done_out)
    );

    initial forever #5 clk_in = ~clk_in;

    logic [7:0]  sbox     [256];
    logic [7:0]  rcon_rom [64];
    logic [31:0] ref_w    [60];
    logic [31:0] dut_w    [60];
    int n_chk  = 0;
    int n_pass = 0;

    always @(posedge clk_in) begin
        rcon_data_in <= rcon_rom[rcon_addr_out];
        sbox_data_in <= {sbox[sbox_addr_out[31:24]], sbox[sbox_addr_out[23:16]],
                         sbox[sbox_addr_out[15:8]],  sbox[sbox_addr_out[7:0]]};
    end

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    // S-box from its definition: GF(2^8) inverse followed by the affine map
    task automatic build_tables();
        logic [7:0] inv;
        logic [7:0] rc;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++) begin
                if (gf_mul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            end
            sbox[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
        for (int j = 0; j < 64; j++) rcon_rom[j] = 8'h00;
        rc = 8'h01;
        for (int j = 1; j <= 10; j++) begin
            rcon_rom[j] = rc;
            rc = gf_mul(rc, 8'h02);
        end
    endtask

    task automatic model_expand(input logic [255:0] key, input int nk);
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) ref_w[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < 4 * (nk + 7); i++) begin
            t = ref_w[i-1];
            if (i % nk == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gf_mul(rc, 8'h02);
            end else if (nk == 8 && i % nk == 4) begin
                t = sub_word(t);
            end
            ref_w[i] = ref_w[i-nk] ^ t;
        end
    endtask

    task automatic chk_outs_zero(input string tag);
        chk(tag, 96'({busy_out, done_out, wrd_valid_out, wrd_idx_out, wrd_out, sbox_addr_out, rcon_addr_out}),
            96'(0));
    endtask

    task automatic run_exp(input string tag, input logic [1:0] sel, input logic [255:0] key,
                           input int ready_pct, input int abort_idx, input int glitch_idx);
        int nk, total, got, cyc, exp_rcon;
        logic rdy, stalled, early_done, aborted;
        logic [31:0] held_w, exp_sa;
        logic [5:0]  held_i;
        nk    = (sel == 2'd2) ? 8 : (sel == 2'd1) ? 6 : 4;
        total = 4 * (nk + 7);
        model_expand(key, nk);
        for (int i = 0; i < 60; i++) dut_w[i] = 32'h0;

        @(negedge clk_in);
        key_in = key; nk_sel_in = sel; start_in = 1'b1; wrd_ready_in = 1'b0;
        @(negedge clk_in);
        start_in = 1'b0;
        chk({tag, " busy"}, 96'(busy_out), 96'(1));

        got = 0; cyc = 0; stalled = 1'b0; early_done = 1'b0; aborted = 1'b0;
        held_w = 32'h0; held_i = 6'h0;
        while (got < total && cyc < 2000) begin
            if (stalled)
                chk({tag, " stall"}, 96'({wrd_valid_out, wrd_idx_out, wrd_out}), 96'({1'b1, held_i, held_w}));
            if (done_out) early_done = 1'b1;
            if (wrd_valid_out && int'(wrd_idx_out) == abort_idx) begin
                aborted = 1'b1;
                break;
            end
            if (wrd_valid_out && int'(wrd_idx_out) == glitch_idx) begin
                start_in = 1'b1; nk_sel_in = 2'd2; key_in = ~key;
            end else begin
                start_in = 1'b0;
            end
            rdy = (int'($urandom_range(99)) < ready_pct);
            wrd_ready_in = rdy;
            if (wrd_valid_out && rdy) begin
                chk({tag, " idx"}, 96'(wrd_idx_out), 96'(got));
                chk({tag, " word"}, 96'(wrd_out), 96'(ref_w[got]));
                dut_w[got] = wrd_out;
                if (got >= nk) begin
                    exp_sa = (got % nk == 0) ? {ref_w[got-1][23:0], ref_w[got-1][31:24]} : ref_w[got-1];
                    chk({tag, " sbox_addr"}, 96'(sbox_addr_out), 96'(exp_sa));
                    if (got % nk == 0) begin
`ifdef RCON_XTIME_EN
                        exp_rcon = 0;
`else
                        exp_rcon = got / nk;
`endif
                        chk({tag, " rcon_addr"}, 96'(rcon_addr_out), 96'(exp_rcon));
                    end
                end
                got++;
                stalled = 1'b0;
            end else if (wrd_valid_out) begin
                stalled = 1'b1; held_w = wrd_out; held_i = wrd_idx_out;
            end else begin
                stalled = 1'b0;
            end
            @(negedge clk_in);
            cyc++;
        end
        start_in = 1'b0;

        if (aborted) begin
            rst_in = 1'b1;
            wrd_ready_in = 1'b0;
            @(negedge clk_in);
            chk_outs_zero({tag, " reset_outs"});
            rst_in = 1'b0;
        end else begin
            wrd_ready_in = 1'b0;
            chk({tag, " count"}, 96'(got), 96'(total));
            chk({tag, " early_done"}, 96'(early_done), 96'(0));
            chk({tag, " done"}, 96'({done_out, busy_out}), 96'(2'b10));
            @(negedge clk_in);
            chk({tag, " idle"}, 96'({done_out, busy_out, wrd_valid_out}), 96'(0));
        end
    endtask

    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    initial begin
        logic [255:0] rkey;
        build_tables();
        rst_in = 1'b1; start_in = 1'b0; nk_sel_in = 2'd0; key_in = '0; wrd_ready_in = 1'b0;
        repeat (3) @(negedge clk_in);
        chk_outs_zero("reset_outs");
        rst_in = 1'b0;
        @(negedge clk_in);
        chk_outs_zero("idle_outs");

        run_exp("aes128", 2'd0, K128, 100, -1, -1);
        chk("aes128 w4", 96'(dut_w[4]), 96'(32'ha0fafe17));
        chk("aes128 w43", 96'(dut_w[43]), 96'(32'hb6630ca6));

        run_exp("aes192", 2'd1, K192, 100, -1, -1);
        chk("aes192 w6", 96'(dut_w[6]), 96'(32'hfe0c91f7));
        chk("aes192 w51", 96'(dut_w[51]), 96'(32'h01002202));

        run_exp("aes256", 2'd2, K256, 100, -1, -1);
        chk("aes256 w8", 96'(dut_w[8]), 96'(32'h9ba35411));
        chk("aes256 w12", 96'(dut_w[12]), 96'(32'ha8b09c1a));
        chk("aes256 w59", 96'(dut_w[59]), 96'(32'h706c631e));

        run_exp("aes128_bp", 2'd0, K128, 50, -1, -1);
        chk("aes128_bp w43", 96'(dut_w[43]), 96'(32'hb6630ca6));

        run_exp("aes128_abort", 2'd0, K128, 100, 20, -1);
        run_exp("aes128_rerun", 2'd0, K128, 100, -1, -1);
        chk("rerun w43", 96'(dut_w[43]), 96'(32'hb6630ca6));

        run_exp("aes128_glitch", 2'd0, K128, 70, -1, 10);
        chk("glitch w43", 96'(dut_w[43]), 96'(32'hb6630ca6));

        for (int s = 0; s < 4; s++) begin
            rkey = {$urandom(), $urandom(), $urandom(), $urandom(),
                    $urandom(), $urandom(), $urandom(), $urandom()};
            run_exp($sformatf("rand_sel%0d", s), 2'(s), rkey, 60, -1, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
